pipe_fetch_stage: RTL
=====================

// Module: pipe_fetch_stage
// PURPOSE
//  Instruction-fetch (IF) stage of the 5-stage pipelined CPU; it feeds the IF/ID pipeline register.
//  - Holds the PC and selects next-PC from pcsource: pc+4, branch, jr or jump.
//  - Fetches from instruction memory over a req/ready handshake.
//  - Presents pc4/ins/ins_valid to IF/ID and stalls the front end while memory is waiting.
//  - Delayed-branch semantics: the word fetched after a branch is its delay slot.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded by reset
//  CNT_W      16             width of saturating fetch-stall counter
// PORTS
//  clk          in   1      clock; all state on rising edge
//  clr          in   1      reset, synchronous, active-high
//  pcen         in   1      advance enable from hazard unit (0 = load-dependency stall)
//  pcsource     in   2      next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
//  bpc          in   32     branch target from ID
//  rpc          in   32     jr register target from ID
//  jpc          in   32     jump target from ID
//  imem_req     out  1      fetch request
//  imem_addr    out  32     fetch word address (byte address, [1:0]=00)
//  imem_rdata   in   32     instruction word, valid when imem_ready=1
//  imem_ready   in   1      memory returns data this cycle
//  pc4          out  32     PC+4 of captured instruction (to IF/ID)
//  ins          out  32     captured instruction (to IF/ID)
//  ins_valid    out  1      pc4/ins hold a valid instruction; IF/ID enable = pcen & ins_valid
//  misalign     out  1      sticky: a selected target had [1:0]!=00
//  stall_cnt    out  CNT_W  saturating count of cycles with imem_req=1 & imem_ready=0
// BEHAVIOUR
//  Reset (clr=1 at edge): pc=RESET_PC, state=S_REQ, pc4=0, ins=0, ins_valid=0, misalign=0, stall_cnt=0.
//   clr wins over every other input; imem_ready in the clr cycle is ignored.
//  npc = {sel[31:2],2'b00}, sel chosen by pcsource; 00 uses pc4. If sel[1:0]!=0, misalign<=1 when npc is loaded.
//  States:
//   S_REQ:  imem_req=1, imem_addr=pc.
//     ready=0: stay; stall_cnt++ (saturates at all-ones).
//     ready=1: ins<=rdata, pc4<=pc+4 (mod 2^32), ins_valid<=1, go S_HOLD.
//     pcen/pcsource are ignored; ID is frozen since ins_valid=0.
//   S_HOLD: outputs stable.
//     pcen=0: imem_req=0, hold everything (load-dependency stall).
//     pcen=1: IF/ID loads pc4/ins this edge; imem_req=1, imem_addr=npc (combinational from pcen/pcsource); pc<=npc.
//       ready=1 same cycle: capture next word, pc4<=npc+4, stay S_HOLD (1 instr/cycle).
//       ready=0: ins_valid<=0, go S_REQ; stall_cnt++.
//  Latency: zero-wait memory gives 1 cycle from reset release to first ins_valid, then 1 instr/cycle.
//   N-wait memory adds N cycles per fetch.
//  pc wraps 32'hFFFF_FFFC -> 0; pc4 likewise.
//  Memory contract: imem_addr is stable while imem_req=1 & ready=0; memory abandons any pending request on clr.
//  Reset mid-fetch: next cycle is S_REQ at RESET_PC; any late ready is treated as for the new request.
// STRUCTURE
//  pipe_pkg: PCSRC_PC4/BR/JR/JMP 2-bit constants, S_REQ/S_HOLD state encoding, RESET_PC default.
//  Sub-module pipe_npc_mux: combinational 4:1 next-PC mux plus misalign detect; instantiated once.
//  FSM, pc/pc4/ins registers and stall counter stay in this module.
// TESTING
//  1 Reset: clr=1 2 cycles -> imem_req=1, imem_addr=0, ins_valid=0, pc4=0, ins=0, stall_cnt=0.
//  2 Zero-wait stream: ready=1, pcen=1, pcsource=00, rdata=addr^32'hA5A5_0000
//     -> imem_addr 0,4,8,C on consecutive cycles; pc4 4,8,C,10; ins_valid stays 1.
//  3 Wait states: ready low 3 cycles per fetch
//     -> imem_addr stable during wait, ins_valid=0 for 3 cycles, stall_cnt +3 per fetch.
//  4 Load stall: in S_HOLD at pc4=8, pcen=0 for 2 cycles -> imem_req=0, pc4=8 and ins unchanged; pcen=1 -> addr 8 issued.
//  5 Redirects: pcsource=01 bpc=0x100 -> next addr 0x100, pc4=0x104;
//     10 rpc=0x203 -> addr 0x200, misalign=1 and stays 1; 11 jpc=0x40 -> addr 0x40.
//  6 Reset mid-wait: clr=1 while S_REQ ready=0 at addr 0x100 -> next cycle addr=RESET_PC, ins_valid=0, stall_cnt=0.
//  Also: stall_cnt saturation at 16'hFFFF; pc wrap from 32'hFFFF_FFFC -> pc4=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   PCSRC_*          next-PC select codes driven by the ID stage
//   fetch_state_t    fetch FSM state encoding
//   RESET_PC_DEFAULT PC loaded on reset unless the top overrides it
//   word_align()     clears the byte-offset bits of an address
package pipe_pkg;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pcsource   in   2   select: pc+4, branch, jr, jump
//   pc4        in   32  sequential successor of the captured instruction
//   bpc        in   32  branch target
//   rpc        in   32  register (jr) target
//   jpc        in   32  jump target
//   npc        out  32  selected target, word aligned
//   misaligned out  1   selected target had non-zero byte offset
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] npc,
  output logic        misaligned
);

  logic [31:0] sel;

  always_comb begin
    sel = pc4;
    case (pcsource)
      PCSRC_PC4: sel = pc4;
      PCSRC_BR:  sel = bpc;
      PCSRC_JR:  sel = rpc;
      PCSRC_JMP: sel = jpc;
      default:   sel = pc4;
    endcase
  end

  // Low bits are dropped rather than trapped; the sticky flag lets software see it happened.
  assign npc        = word_align(sel);
  assign misaligned = (sel[1:0] != 2'b00);

endmodule

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake
// and presents pc4/ins/ins_valid to the IF/ID register.
// Ports:
//   clk, clr          clock; synchronous active-high reset
//   pcen              advance enable from hazard unit
//   pcsource          next-PC select (see pipe_pkg)
//   bpc, rpc, jpc     redirect targets from ID
//   imem_req/addr     fetch request and word address
//   imem_rdata/ready  returned instruction and its strobe
//   pc4, ins          captured instruction and its successor PC
//   ins_valid         pc4/ins hold a valid instruction
//   misalign          sticky: a loaded target had a byte offset
//   stall_cnt         saturating count of memory wait cycles
//
// state  | meaning
// S_REQ  | request outstanding for pc; IF/ID holds nothing valid
// S_HOLD | instruction captured; next fetch issued whenever pcen=1
module pipe_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pcen,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      bpc,
  input  logic [31:0]      rpc,
  input  logic [31:0]      jpc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      pc4,
  output logic [31:0]      ins,
  output logic             ins_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  npc;
  logic         npc_misaligned;
  logic         stall;
  logic         advance;

  pipe_npc_mux u_npc_mux (
    .pcsource   (pcsource),
    .pc4        (pc4),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .npc        (npc),
    .misaligned (npc_misaligned)
  );

  // In S_HOLD the next address goes straight to memory in the same cycle
  // IF/ID consumes the current word, giving one instruction per cycle.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = pc;
    advance   = 1'b0;
    case (state)
      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ready) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (pcen) begin
          advance   = 1'b1;
          imem_req  = 1'b1;
          imem_addr = npc;
          if (!imem_ready) state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign stall = imem_req & ~imem_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      pc4       <= '0;
      ins       <= '0;
      ins_valid <= 1'b0;
      misalign  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            ins       <= imem_rdata;
            pc4       <= pc + 32'd4;
            ins_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (advance) begin
            pc <= npc;
            if (npc_misaligned) misalign <= 1'b1;
            if (imem_ready) begin
              ins <= imem_rdata;
              pc4 <= npc + 32'd4;
            end else begin
              ins_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
